// File: rtl/pc_sequencer.sv
// pc_sequencer: D-bit program counter with an IDLE/RUN/HALT control FSM.
// Each RUN cycle it either halts, stalls, takes a relative jump whose offset
// comes from the branch-offset LUT, or increments. The LUT is addressed
// combinationally and returns its offset within the same cycle.
module pc_sequencer #(
   parameter int unsigned D  = 12,
   parameter int unsigned CW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [D-1:0]  start_addr,
   input  logic          stall,
   input  logic          halt_req,
   input  logic          jump_req,
   input  logic [1:0]    jump_sel,
   output logic [1:0]    lut_addr,
   input  logic [D-1:0]  target,
   output logic [D-1:0]  prog_ctr,
   output logic          running,
   output logic          done,
   output logic          flush,
   output logic [CW-1:0] jump_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   localparam logic [CW-1:0] CNT_MAX = '1;

   state_t        state;
   state_t        state_nxt;
   logic [D-1:0]  pc_nxt;
   logic [CW-1:0] cnt_nxt;
   logic          flush_nxt;
   logic          running_nxt;
   logic          done_nxt;

   // LUT address is a straight pass-through of the decode select
   assign lut_addr = jump_sel;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state plus next PC / counter / flush, RUN priority halt > stall > jump > increment
   always_comb begin
      state_nxt = state;
      pc_nxt    = prog_ctr;
      cnt_nxt   = jump_cnt;
      flush_nxt = 1'b0;
      case (state)
         IDLE, HALT: begin
            if (start) begin
               state_nxt = RUN;
               pc_nxt    = start_addr;
               cnt_nxt   = '0;
            end
         end
         RUN: begin
            if (halt_req) begin
               state_nxt = HALT;
            end else if (stall) begin
               // jump_req dropped here; decode re-presents it
               pc_nxt = prog_ctr;
            end else if (jump_req) begin
               // a zero offset is the LUT hold entry: not a taken jump
               if (target != '0) begin
                  pc_nxt    = prog_ctr + target;
                  flush_nxt = 1'b1;
                  if (jump_cnt != CNT_MAX) begin
                     cnt_nxt = jump_cnt + CW'(1);
                  end
               end
            end else begin
               pc_nxt = prog_ctr + D'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Status outputs decoded from the next state
   always_comb begin
      running_nxt = 1'b0;
      done_nxt    = 1'b0;
      if (state_nxt == RUN) begin
         running_nxt = 1'b1;
      end
      if (state_nxt == HALT) begin
         done_nxt = 1'b1;
      end
   end

   // Registered datapath and status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prog_ctr <= '0;
         jump_cnt <= '0;
         running  <= 1'b0;
         done     <= 1'b0;
         flush    <= 1'b0;
      end else begin
         prog_ctr <= pc_nxt;
         jump_cnt <= cnt_nxt;
         running  <= running_nxt;
         done     <= done_nxt;
         flush    <= flush_nxt;
      end
   end

endmodule
